// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single combinational instruction ROM; one grant per cycle, data returned one cycle later.
// Optional aging for the loader port is enabled by defining ROM_ARB_AGING_EN (default: strict port-0 priority).
module rom_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_P0   = 2'd1,
        R_P1   = 2'd2
    } resp_st_t;

    resp_st_t          r_resp_st;
    resp_st_t          w_resp_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_aged;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

`ifdef ROM_ARB_AGING_EN
    logic [3:0] r_wait_cnt;

    assign w_aged = req1 && (r_wait_cnt == 4'(MAX_WAIT));

    // Counts consecutive cycles port 1 has been refused; saturates at the threshold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (!req1 || w_gnt1) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != 4'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end
`else
    assign w_aged = 1'b0;
`endif

    // Grants are gated by rst so the ROM is idle during reset regardless of requests.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_resp_nxt = R_IDLE;
        if (rst) begin
            if (w_aged) begin
                w_gnt1 = 1'b1;
            end else if (req0) begin
                w_gnt0 = 1'b1;
            end else if (req1) begin
                w_gnt1 = 1'b1;
            end
        end
        if (w_gnt0) begin
            w_resp_nxt = R_P0;
        end else if (w_gnt1) begin
            w_resp_nxt = R_P1;
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign rom_ce   = w_gnt0 | w_gnt1;
    assign rom_addr = w_gnt0 ? addr0 : (w_gnt1 ? addr1 : '0);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_st <= R_IDLE;
        end else begin
            r_resp_st <= w_resp_nxt;
        end
    end

    // Read-data registers only load on their own port's grant, holding value between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_gnt0) begin
                r_rdata0 <= rom_inst;
            end
            if (w_gnt1) begin
                r_rdata1 <= rom_inst;
            end
        end
    end

    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign rvalid0 = (r_resp_st == R_P0);
    assign rvalid1 = (r_resp_st == R_P1);

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: the driver pushes expected read responses, a monitor pops them on rvalid.
// Contention expectations follow ROM_ARB_AGING_EN when it is defined for the build.
module tb_rom_arbiter;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic [DATA_W-1:0] rdata0;
    logic              rvalid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid1;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    logic [DATA_W-1:0] rom [2**ADDR_W];
    exp_t              q0[$];
    exp_t              q1[$];
    exp_t              e0;
    exp_t              e1;
    logic [DATA_W-1:0] last0;
    logic [DATA_W-1:0] last1;
    int                checks;
    int                errors;
    int                cyc;

    rom_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .addr0   (addr0),
        .gnt0    (gnt0),
        .rdata0  (rdata0),
        .rvalid0 (rvalid0),
        .req1    (req1),
        .addr1   (addr1),
        .gnt1    (gnt1),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1),
        .rom_ce  (rom_ce),
        .rom_addr(rom_addr),
        .rom_inst(rom_inst)
    );

    assign rom_inst = rom_ce ? rom[rom_addr] : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One grant cycle: drive requests, check the grant at negedge, book the expected response.
    task automatic step(input logic r0, input logic [ADDR_W-1:0] a0,
                        input logic r1, input logic [ADDR_W-1:0] a1,
                        input logic eg0, input logic eg1);
        exp_t e;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        @(negedge clk);
        check("gnt0", 32'(gnt0), 32'(eg0));
        check("gnt1", 32'(gnt1), 32'(eg1));
        check("rom_ce", 32'(rom_ce), 32'(eg0 | eg1));
        check("rom_addr", 32'(rom_addr), eg0 ? 32'(a0) : (eg1 ? 32'(a1) : 32'd0));
        if (eg0) begin
            e.data = rom[a0];
            e.due  = cyc + 1;
            q0.push_back(e);
            last0 = rom[a0];
        end
        if (eg1) begin
            e.data = rom[a1];
            e.due  = cyc + 1;
            q1.push_back(e);
            last1 = rom[a1];
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest booked response and arrive exactly on time.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("rvalid_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
            check("rvalid0_overdue", 32'((q0.size() > 0) && (q0[0].due < cyc)), 32'd0);
            check("rvalid1_overdue", 32'((q1.size() > 0) && (q1[0].due < cyc)), 32'd0);
            if (rvalid0) begin
                if (q0.size() == 0) begin
                    check("rvalid0_unexpected", 32'(rvalid0), 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    check("rvalid0_cycle", 32'(cyc), 32'(e0.due));
                    check("rdata0", rdata0, e0.data);
                end
            end
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    check("rvalid1_unexpected", 32'(rvalid1), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("rvalid1_cycle", 32'(cyc), 32'(e1.due));
                    check("rdata1", rdata1, e1.data);
                end
            end
        end
    end

    initial begin
        logic eg1;
        checks = 0;
        errors = 0;
        last0  = '0;
        last1  = '0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            rom[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        end
        rom[0]  = 32'h0BAD_F00D;
        rom[5]  = 32'hDEAD_BEEF;
        rom[9]  = 32'h5555_AAAA;
        rom[63] = 32'hCAFE_F00D;

        rst   = 1'b0;
        req0  = 1'b0;
        addr0 = '0;
        req1  = 1'b0;
        addr1 = '0;
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("reset_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check("reset_rom_ce", 32'(rom_ce), 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_rdata1", rdata1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single fetch of word 5, then a single loader fetch.
        step(1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 1'b0);
        step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b0, 6'd0, 1'b1, 6'd9, 1'b0, 1'b1);
        step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);

        // Continuous contention: port 1 only breaks through with aging, every MAX_WAIT+1 cycles.
        for (int i = 0; i < 10; i++) begin
`ifdef ROM_ARB_AGING_EN
            eg1 = (i == 4) || (i == 9);
`else
            eg1 = 1'b0;
`endif
            step(1'b1, 6'd5, 1'b1, 6'd63, !eg1, eg1);
        end
        step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);

        // Alternating ports at the two address extremes.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, (i % 4 == 0) ? 6'd0 : 6'd63, 1'b0, 6'd0, 1'b1, 1'b0);
            end else begin
                step(1'b0, 6'd0, 1'b1, (i % 4 == 1) ? 6'd63 : 6'd0, 1'b0, 1'b1);
            end
        end

        // Reset while a response is in flight.
        step(1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 1'b0);
        req0  = 1'b1;
        addr0 = 6'd7;
        rst   = 1'b0;
        #1;
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_rom_ce", 32'(rom_ce), 32'd0);
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        @(negedge clk);
        check("rst_hold_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        step(1'b1, 6'd7, 1'b0, 6'd0, 1'b1, 1'b0);

        // Idle: nothing granted, read data held.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
            if (i > 0) begin
                check("idle_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
            end
            check("idle_rdata0", rdata0, last0);
            check("idle_rdata1", rdata1, last1);
        end

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning ROM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, meaning the aging threshold in cycles, range 1..15.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port req0  input  1  meaning fetch-port read request, held until gnt0.
REQ-007 SHALL have port addr0  input  ADDR_W  meaning fetch-port word address, stable while req0 is high.
REQ-008 SHALL have ports gnt0  output  1, rdata0  output  DATA_W and rvalid0  output  1, meaning the fetch-port grant, read data and data-valid strobe.
REQ-009 SHALL have ports req1  input  1, addr1  input  ADDR_W, gnt1  output  1, rdata1  output  DATA_W and rvalid1  output  1, meaning the same set of signals for the loader/debug port.
REQ-010 SHALL have ports rom_ce  output  1, rom_addr  output  ADDR_W and rom_inst  input  DATA_W, meaning the shared ROM port; ROM data is combinational from ce/addr.

Function
REQ-011 SHALL grant at most one port per cycle; gnt0 and gnt1 are combinational from the requests and the wait counter, and are never both high.
REQ-012 SHALL drive rom_ce=1 and rom_addr=addr of the granted port in the grant cycle; with no grant it drives rom_ce=0 and rom_addr=0.
REQ-013 SHALL capture rom_inst into the winner's rdata register at the rising edge that ends the grant cycle, and pulse that port's rvalid high for exactly one cycle (fixed latency 1).
REQ-014 SHALL hold rdataX unchanged between rvalidX pulses.
REQ-015 SHALL track the response with a state register, resp_st ∈ {R_IDLE, R_P0, R_P1}: next state is R_P0 if gnt0, R_P1 if gnt1, otherwise R_IDLE; rvalid0=(resp_st==R_P0) and rvalid1=(resp_st==R_P1).
REQ-016 SHALL sustain one grant per cycle, so back-to-back requests from either port give continuous rvalid pulses.
REQ-017 SHALL, when only one port requests, grant that port in the same cycle.
REQ-018 SHALL, when both ports request, resolve priority per REQ-022/REQ-023.
REQ-019 SHALL return the correct data for addr wrap-around at 2^ADDR_W-1 -> 0, with no special handling.

Reset
REQ-020 SHALL, while rst=0, force resp_st=R_IDLE, rvalid0=rvalid1=0, rdata0=rdata1=0, wait_cnt=0, gnt0=gnt1=0 and rom_ce=0, asynchronously.
REQ-021 SHALL discard a response pending when reset asserts mid-operation: no rvalid is issued after release, and the first grant is possible in the first clock after release.

Configuration
REQ-022 SHALL, with ROM_ARB_AGING_EN defined, keep a 4-bit wait_cnt that increments, saturating at MAX_WAIT, each cycle req1=1 and gnt1=0; it clears when gnt1=1 or req1=0; when wait_cnt==MAX_WAIT and req1=1, port 1 wins over port 0.
REQ-023 SHALL, without ROM_ARB_AGING_EN, use strict port-0 priority and include no wait_cnt logic; port 1 can starve.

Verification
REQ-024 SHALL cover: ROM word 5=0xDEADBEEF, req0 with addr0=5 for one cycle -> gnt0 high that cycle, rvalid0 high the next cycle with rdata0=0xDEADBEEF, rvalid1 stays 0.
REQ-025 SHALL cover: req0 and req1 both high continuously with aging off -> gnt0 every cycle, gnt1 never, rvalid0 continuous.
REQ-026 SHALL cover: the same stimulus with ROM_ARB_AGING_EN and MAX_WAIT=4 -> gnt1 in the 5th cycle, gnt0 in the others, wait_cnt back to 0 after gnt1.
REQ-027 SHALL cover: alternating req0/req1 at addresses 0 and 63 -> rvalid alternates between ports each cycle with the correct data, including address 63.
REQ-028 SHALL cover: rst driven low between a grant and its rvalid cycle -> rvalid0/1 are 0 immediately, stay 0 after release, and the next req0 is granted in the first cycle after release.
REQ-029 SHALL cover: no requests for 10 cycles -> rom_ce=0, rom_addr=0, gnt and rvalid all 0, rdata unchanged.
